// File: rtl/adc_sequencer.sv
// ADS1256-style conversion sequencer driving an SPI master: SELFCAL, then
// one RDATA read per DRDY falling edge, with missed-edge and timeout flags.
// Ports: clock_i/reset_i (sync, active high), enable_i, DRDY_L_i (async),
//   spi_start_o/spi_tx_buffer_o/spi_mode_o -> spi, spi_done_i/spi_rx_buffer_i <- spi,
//   sample_o/sample_valid_o, missed_o, error_o, busy_o.

package adc_sequencer_pkg;
    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_TX    = 2'd1,
        SPI_TX_RX = 2'd2
    } spi_mode_t;
endpackage

module adc_sequencer
    import adc_sequencer_pkg::*;
#(
    parameter logic [7:0]  CMD_SELFCAL  = 8'hF0,
    parameter logic [7:0]  CMD_RDATA    = 8'h01,
    parameter logic [31:0] DRDY_TIMEOUT = 32'd400_000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        DRDY_L_i,
    output logic        spi_start_o,
    output logic [7:0]  spi_tx_buffer_o,
    output spi_mode_t   spi_mode_o,
    input  logic        spi_done_i,
    input  logic [23:0] spi_rx_buffer_i,
    output logic [23:0] sample_o,
    output logic        sample_valid_o,
    output logic [7:0]  missed_o,
    output logic        error_o,
    output logic        busy_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CAL_START,
        S_CAL_BUSY,
        S_CAL_WAIT,
        S_RUN_WAIT,
        S_READ_START,
        S_READ_BUSY,
        S_OUTPUT,
        S_ERROR
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        sync2_q;
    logic        prev_q;
    logic [31:0] tcnt_q;
    logic        start_q;
    logic [7:0]  tx_q;
    spi_mode_t   mode_q;
    logic [23:0] sample_q;
    logic        valid_q;
    logic [7:0]  missed_q;
    logic        error_q;

    logic drdy_fall;
    logic in_read;
    logic tmo_hit;

    assign drdy_fall = prev_q & ~sync2_q;
    assign in_read   = (state_q == S_READ_START) ||
                       (state_q == S_READ_BUSY) ||
                       (state_q == S_OUTPUT);
    assign tmo_hit   = (tcnt_q == DRDY_TIMEOUT - 32'd1);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            tcnt_q   <= '0;
            start_q  <= 1'b0;
            tx_q     <= '0;
            mode_q   <= SPI_IDLE;
            sample_q <= '0;
            valid_q  <= 1'b0;
            missed_q <= '0;
            error_q  <= 1'b0;
        end else begin
            sync1_q <= DRDY_L_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            start_q <= 1'b0;
            valid_q <= 1'b0;

            // Edges during a read are counted, never queued.
            if (drdy_fall && in_read && missed_q != 8'hFF)
                missed_q <= missed_q + 8'd1;

            unique case (state_q)
                S_IDLE: begin
                    mode_q <= SPI_IDLE;
                    if (enable_i && !error_q)
                        state_q <= S_CAL_START;
                end
                S_CAL_START: begin
                    start_q <= 1'b1;
                    tx_q    <= CMD_SELFCAL;
                    mode_q  <= SPI_TX;
                    state_q <= S_CAL_BUSY;
                end
                S_CAL_BUSY: begin
                    if (spi_done_i) begin
                        mode_q  <= SPI_IDLE;
                        tcnt_q  <= '0;
                        state_q <= enable_i ? S_CAL_WAIT : S_IDLE;
                    end
                end
                S_CAL_WAIT: begin
                    // A DRDY edge on the timeout cycle still counts as success.
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if (drdy_fall) begin
                        tcnt_q  <= '0;
                        state_q <= S_RUN_WAIT;
                    end else if (tmo_hit) begin
                        error_q <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        tcnt_q <= tcnt_q + 32'd1;
                    end
                end
                S_RUN_WAIT: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if (drdy_fall) begin
                        state_q <= S_READ_START;
                    end else if (tmo_hit) begin
                        error_q <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        tcnt_q <= tcnt_q + 32'd1;
                    end
                end
                S_READ_START: begin
                    start_q <= 1'b1;
                    tx_q    <= CMD_RDATA;
                    mode_q  <= SPI_TX_RX;
                    state_q <= S_READ_BUSY;
                end
                S_READ_BUSY: begin
                    if (spi_done_i) begin
                        sample_q <= spi_rx_buffer_i;
                        valid_q  <= 1'b1;
                        mode_q   <= SPI_IDLE;
                        state_q  <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    tcnt_q  <= '0;
                    state_q <= enable_i ? S_RUN_WAIT : S_IDLE;
                end
                S_ERROR: begin
                    if (!enable_i) begin
                        error_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spi_start_o     = start_q;
    assign spi_tx_buffer_o = tx_q;
    assign spi_mode_o      = mode_q;
    assign sample_o        = sample_q;
    assign sample_valid_o  = valid_q;
    assign missed_o        = missed_q;
    assign error_o         = error_q;
    assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_sequencer.sv
// Scoreboard bench for adc_sequencer: SPI slave model, DRDY generator,
// expected commands/samples queued by the stimulus, popped by a monitor.

module tb_adc_sequencer;
    import adc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        drdy = 1'b1;
    logic        done = 1'b0;
    logic [23:0] rx = '0;
    logic        start;
    logic [7:0]  tx;
    spi_mode_t   mode;
    logic [23:0] sample;
    logic        valid;
    logic [7:0]  missed;
    logic        err;
    logic        busy;

    adc_sequencer #(
        .CMD_SELFCAL (8'hF0),
        .CMD_RDATA   (8'h01),
        .DRDY_TIMEOUT(32'd1000)
    ) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .enable_i       (en),
        .DRDY_L_i       (drdy),
        .spi_start_o    (start),
        .spi_tx_buffer_o(tx),
        .spi_mode_o     (mode),
        .spi_done_i     (done),
        .spi_rx_buffer_i(rx),
        .sample_o       (sample),
        .sample_valid_o (valid),
        .missed_o       (missed),
        .error_o        (err),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nerr = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [7:0] tx;
        spi_mode_t  mode;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [23:0] exp_smp[$];
    cmd_t        last_cmd;

    function automatic void push_cmd(logic [7:0] t, spi_mode_t m);
        cmd_t c;
        c.tx = t;
        c.mode = m;
        exp_cmd.push_back(c);
    endfunction

    // SPI slave model and DRDY generator (period 600 cycles, 20 high)
    int spi_lat = 200;
    int spi_cnt = 0;
    bit spi_busy = 0;
    int done_cyc = 0;
    bit drdy_run = 0;
    int ph = 580;
    int fall_cyc = -1000;

    always @(negedge clk) begin
        done = 1'b0;
        if (rst) begin
            spi_busy = 0;
        end else begin
            if (spi_busy) begin
                if (spi_cnt <= 1) begin
                    done = 1'b1;
                    spi_busy = 0;
                    done_cyc = cyc;
                    check("tx_held", tx, last_cmd.tx);
                    check("mode_held", mode, last_cmd.mode);
                end else begin
                    spi_cnt--;
                end
            end
            if (start) begin
                spi_busy = 1;
                spi_cnt = spi_lat;
            end
        end
        if (!drdy_run) begin
            drdy = 1'b1;
            ph = 580;
        end else begin
            ph = (ph == 599) ? 0 : ph + 1;
            drdy = (ph >= 580);
            if (ph == 0) fall_cyc = cyc;
        end
    end

    // Monitor
    logic prev_start = 1'b0;
    logic prev_valid = 1'b0;
    bit   chk_en = 0;
    int   en_cyc = 0;
    int   nstart = 0;
    int   nsamp = 0;

    always @(negedge clk) begin
        if (start) begin
            nstart++;
            check("start_expected", 32'(exp_cmd.size() != 0), 1);
            if (exp_cmd.size() != 0) begin
                last_cmd = exp_cmd.pop_front();
                check("cmd_tx", tx, last_cmd.tx);
                check("cmd_mode", mode, last_cmd.mode);
                if (last_cmd.tx == 8'h01)
                    check("read_latency", 32'(cyc - fall_cyc), 4);
            end
            if (chk_en) begin
                check("enable_latency", 32'(cyc - en_cyc), 2);
                chk_en = 0;
            end
            check("start_width", prev_start, 0);
        end
        if (valid) begin
            nsamp++;
            check("valid_expected", 32'(exp_smp.size() != 0), 1);
            if (exp_smp.size() != 0)
                check("sample", sample, exp_smp.pop_front());
            check("valid_latency", 32'(cyc - done_cyc), 1);
            check("valid_width", prev_valid, 0);
        end
        prev_start = start;
        prev_valid = valid;
    end

    task automatic wait_cmds(input int budget, input string what);
        int k = 0;
        while (exp_cmd.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({what, "_cmd_wait"}, 32'(exp_cmd.size()), 0);
    endtask

    task automatic wait_smps(input int budget, input string what);
        int k = 0;
        while (exp_smp.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({what, "_smp_wait"}, 32'(exp_smp.size()), 0);
    endtask

    task automatic check_reset(input string what);
        check({what, "_start"}, start, 0);
        check({what, "_valid"}, valid, 0);
        check({what, "_error"}, err, 0);
        check({what, "_busy"}, busy, 0);
        check({what, "_sample"}, sample, 0);
        check({what, "_missed"}, missed, 0);
        check({what, "_tx"}, tx, 0);
        check({what, "_mode"}, mode, SPI_IDLE);
    endtask

    initial begin
        int ns0;
        int k;
        int err_cyc;

        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        @(negedge clk);

        // Calibration then three reads
        rx = 24'hAABBCC;
        push_cmd(8'hF0, SPI_TX);
        for (int i = 0; i < 3; i++) begin
            push_cmd(8'h01, SPI_TX_RX);
            exp_smp.push_back(24'hAABBCC);
        end
        en = 1'b1;
        drdy_run = 1;
        en_cyc = cyc;
        chk_en = 1;
        wait_smps(6000, "t1");
        check("t1_missed", missed, 0);
        check("t1_sample_hold", sample, 24'hAABBCC);

        // Long read: one DRDY edge lands in READ_BUSY
        spi_lat = 800;
        rx = 24'h123456;
        push_cmd(8'h01, SPI_TX_RX);
        exp_smp.push_back(24'h123456);
        wait_smps(3000, "t2a");
        spi_lat = 200;
        rx = 24'h654321;
        push_cmd(8'h01, SPI_TX_RX);
        exp_smp.push_back(24'h654321);
        wait_smps(3000, "t2b");
        check("t2_missed", missed, 1);

        // Disable during READ_BUSY
        rx = 24'h0F0F0F;
        push_cmd(8'h01, SPI_TX_RX);
        exp_smp.push_back(24'h0F0F0F);
        wait_cmds(2000, "t3");
        en = 1'b0;
        wait_smps(1000, "t3");
        repeat (2) @(negedge clk);
        check("t3_busy", busy, 0);
        check("t3_mode", mode, SPI_IDLE);
        ns0 = nstart;
        repeat (1500) @(negedge clk);
        check("t3_no_start", 32'(nstart), 32'(ns0));
        drdy_run = 0;
        repeat (5) @(negedge clk);

        // Timeout in CAL_WAIT with DRDY held high
        push_cmd(8'hF0, SPI_TX);
        en = 1'b1;
        en_cyc = cyc;
        chk_en = 1;
        wait_cmds(100, "t4");
        k = 0;
        while (!err && k < 3000) begin
            @(negedge clk);
            k++;
        end
        err_cyc = cyc;
        check("t4_err_seen", err, 1);
        check("t4_err_cycle", 32'(err_cyc - done_cyc), 1001);
        check("t4_mode", mode, SPI_IDLE);
        repeat (500) @(negedge clk);
        check("t4_err_sticky", err, 1);
        check("t4_busy", busy, 1);
        en = 1'b0;
        @(negedge clk);
        check("t4_err_clear", err, 0);
        check("t4_idle", busy, 0);

        // Reset in READ_BUSY, then restart from SELFCAL
        drdy_run = 1;
        rx = 24'h5A5A5A;
        push_cmd(8'hF0, SPI_TX);
        push_cmd(8'h01, SPI_TX_RX);
        en = 1'b1;
        en_cyc = cyc;
        chk_en = 1;
        wait_cmds(3000, "t5");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t5");
        rx = 24'hABCDEF;
        push_cmd(8'hF0, SPI_TX);
        push_cmd(8'h01, SPI_TX_RX);
        exp_smp.push_back(24'hABCDEF);
        rst = 1'b0;
        en_cyc = cyc;
        chk_en = 1;
        wait_smps(5000, "t5");

        en = 1'b0;
        drdy_run = 0;
        repeat (5) @(negedge clk);
        check("end_cmd_queue", 32'(exp_cmd.size()), 0);
        check("end_smp_queue", 32'(exp_smp.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
